// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one step per cycle, with a single-cycle fast path for divide-by-zero and signed overflow.
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       FUNCT3,
    input  logic [XLEN-1:0]  DATA1,
    input  logic [XLEN-1:0]  DATA2,
    input  logic [TAG_W-1:0] TAG_IN,
    input  logic             FLUSH,
    output logic             BUSY,
    output logic             RESULT_VALID,
    output logic [XLEN-1:0]  RESULT,
    output logic [TAG_W-1:0] TAG_OUT
);

    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic                neg_q, neg_d;
    logic                fast_q, fast_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [TAG_W-1:0]    tag_out_q, tag_out_d;
    logic                rv_q, rv_d;

    logic                a_signed_s, b_signed_s, a_neg_s, b_neg_s, neg_s;
    logic [XLEN-1:0]     a_mag_s, b_mag_s;
    logic                dz_s, ovf_s, fast_s;
    logic [XLEN-1:0]     fast_res_s;
    logic [XLEN:0]       sum_s, shl_s, diff_s;
    logic [2*XLEN-1:0]   mul_step_s, div_step_s, mul_fix_s;
    logic [XLEN-1:0]     quo_s, rem_s, fix_res_s;

    // Operand decode at the START edge: magnitudes, result sign and fast-path detection
    always_comb begin
        a_signed_s = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010) || (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
        b_signed_s = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
        a_neg_s    = a_signed_s & DATA1[XLEN-1];
        b_neg_s    = b_signed_s & DATA2[XLEN-1];
        a_mag_s    = a_neg_s ? ({XLEN{1'b0}} - DATA1) : DATA1;
        b_mag_s    = b_neg_s ? ({XLEN{1'b0}} - DATA2) : DATA2;
        // REM follows the dividend sign; the others follow the sign product
        if (FUNCT3 == 3'b110) begin
            neg_s = a_neg_s;
        end else if ((FUNCT3 == 3'b001) || (FUNCT3 == 3'b010) || (FUNCT3 == 3'b100)) begin
            neg_s = a_neg_s ^ b_neg_s;
        end else begin
            neg_s = 1'b0;
        end
        dz_s   = FUNCT3[2] && (DATA2 == {XLEN{1'b0}});
        ovf_s  = ((FUNCT3 == 3'b100) || (FUNCT3 == 3'b110)) &&
                 (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == {XLEN{1'b1}});
        fast_s = dz_s || ovf_s;
        if (dz_s) begin
            fast_res_s = FUNCT3[1] ? DATA1 : {XLEN{1'b1}};
        end else begin
            fast_res_s = FUNCT3[1] ? {XLEN{1'b0}} : DATA1;
        end
    end

    // One radix-2 step: multiply keeps the multiplier in the low half, divide keeps the quotient there
    always_comb begin
        sum_s      = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        mul_step_s = {sum_s, prod_q[XLEN-1:1]};
        shl_s      = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        diff_s     = shl_s - {1'b0, b_q};
        if (!diff_s[XLEN]) begin
            div_step_s = {diff_s[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        end else begin
            div_step_s = {shl_s[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and result selection for the FIX cycle
    always_comb begin
        mul_fix_s = neg_q ? ({(2*XLEN){1'b0}} - prod_q) : prod_q;
        quo_s     = prod_q[XLEN-1:0];
        rem_s     = prod_q[2*XLEN-1:XLEN];
        case (f3_q)
            3'b000:                 fix_res_s = prod_q[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res_s = mul_fix_s[2*XLEN-1:XLEN];
            3'b100:                 fix_res_s = neg_q ? ({XLEN{1'b0}} - quo_s) : quo_s;
            3'b101:                 fix_res_s = quo_s;
            3'b110:                 fix_res_s = neg_q ? ({XLEN{1'b0}} - rem_s) : rem_s;
            3'b111:                 fix_res_s = rem_s;
            default:                fix_res_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic; a fast-path result waits one cycle in prod_q before it is published
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        tag_d     = tag_q;
        prod_d    = prod_q;
        b_d       = b_q;
        neg_d     = neg_q;
        fast_d    = 1'b0;
        result_d  = result_q;
        tag_out_d = tag_out_q;
        rv_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fast_q) begin
                    result_d  = prod_q[XLEN-1:0];
                    tag_out_d = tag_q;
                    rv_d      = 1'b1;
                end else begin
                    rv_d = 1'b0;
                end
                if (START) begin
                    f3_d  = FUNCT3;
                    tag_d = TAG_IN;
                    b_d   = b_mag_s;
                    neg_d = neg_s;
                    cnt_d = CNT_W'(XLEN);
                    if (fast_s) begin
                        fast_d = 1'b1;
                        prod_d = {{XLEN{1'b0}}, fast_res_s};
                    end else begin
                        prod_d  = {{XLEN{1'b0}}, a_mag_s};
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                prod_d = f3_q[2] ? div_step_s : mul_step_s;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: begin
                result_d  = fix_res_s;
                tag_out_d = tag_q;
                rv_d      = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (FLUSH) begin
            state_d   = S_IDLE;
            fast_d    = 1'b0;
            rv_d      = 1'b0;
            result_d  = result_q;
            tag_out_d = tag_out_q;
        end else begin
            fast_d = fast_d;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            f3_q      <= 3'b000;
            tag_q     <= {TAG_W{1'b0}};
            prod_q    <= {(2*XLEN){1'b0}};
            b_q       <= {XLEN{1'b0}};
            neg_q     <= 1'b0;
            fast_q    <= 1'b0;
            result_q  <= {XLEN{1'b0}};
            tag_out_q <= {TAG_W{1'b0}};
            rv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            tag_q     <= tag_d;
            prod_q    <= prod_d;
            b_q       <= b_d;
            neg_q     <= neg_d;
            fast_q    <= fast_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
            rv_q      <= rv_d;
        end
    end

    assign BUSY         = busy_q;
    assign RESULT_VALID = rv_q;
    assign RESULT       = result_q;
    assign TAG_OUT      = tag_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, random ops against a
// plain-arithmetic reference model, and hand-written flush/reset/back-to-back sequences.
module tb_mul_div_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int LAT   = XLEN + 1;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             START = 1'b0;
    logic [2:0]       FUNCT3 = 3'b000;
    logic [XLEN-1:0]  DATA1 = 32'h0;
    logic [XLEN-1:0]  DATA2 = 32'h0;
    logic [TAG_W-1:0] TAG_IN = 5'h0;
    logic             FLUSH = 1'b0;
    logic             BUSY, RESULT_VALID;
    logic [XLEN-1:0]  RESULT;
    logic [TAG_W-1:0] TAG_OUT;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3),
        .DATA1(DATA1), .DATA2(DATA2), .TAG_IN(TAG_IN), .FLUSH(FLUSH),
        .BUSY(BUSY), .RESULT_VALID(RESULT_VALID), .RESULT(RESULT), .TAG_OUT(TAG_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]       f3;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: RV32M results straight from 64-bit integer arithmetic
    function automatic logic [XLEN-1:0] ref_model(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        longint sa, sb, ua, ub, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
            3'd4: begin if (b == 32'h0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 32'h0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 32'h0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 32'h0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return f3[2] && ((b == 32'h0) ||
               ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // Counts cycles (sampled on falling edges) from the START edge until RESULT_VALID, bounded
    task automatic wait_rv(output int cyc, output bit busy_bad, input bit exp_busy);
        cyc = 0;
        busy_bad = 1'b0;
        while (!RESULT_VALID && cyc < 80) begin
            if (BUSY !== exp_busy) busy_bad = 1'b1;
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic do_op(input string nm, input logic [2:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tg, input logic [XLEN-1:0] exp);
        int cyc;
        bit busy_bad, fast;
        fast = is_fast(f3, a, b);
        @(negedge CLK);
        START = 1'b1; FUNCT3 = f3; DATA1 = a; DATA2 = b; TAG_IN = tg;
        @(negedge CLK);
        START = 1'b0; FUNCT3 = 3'($urandom); DATA1 = $urandom; DATA2 = $urandom; TAG_IN = 5'($urandom);
        wait_rv(cyc, busy_bad, !fast);
        chk({nm, " result"}, RESULT, exp);
        chk({nm, " tag"}, TAG_OUT, tg);
        chk({nm, " latency"}, cyc, fast ? 1 : LAT);
        chk({nm, " busy_before_valid"}, busy_bad, 1'b0);
        chk({nm, " busy_in_valid_cycle"}, BUSY, 1'b0);
        @(negedge CLK);
        chk({nm, " valid_one_cycle"}, RESULT_VALID, 1'b0);
        chk({nm, " result_hold"}, RESULT, exp);
    endtask

    vec_t vecs[15];

    initial begin
        int cyc;
        bit busy_bad, seen;
        logic [2:0]      f3;
        logic [XLEN-1:0] a, b;

        vecs[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000};
        vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd4,  32'hFFFFFFFD};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd6,  32'hFFFFFFFF};
        vecs[6]  = '{3'd5, 32'd100,      32'd7,        5'd7,  32'd14};
        vecs[7]  = '{3'd7, 32'd100,      32'd7,        5'd8,  32'd2};
        vecs[8]  = '{3'd5, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF};
        vecs[9]  = '{3'd7, 32'd5,        32'd0,        5'd10, 32'd5};
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000};
        vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000};
        vecs[12] = '{3'd6, 32'hFFFFFFF9, 32'h00000000, 5'd13, 32'hFFFFFFF9};
        vecs[13] = '{3'd1, 32'h80000000, 32'h80000000, 5'd14, 32'h40000000};
        vecs[14] = '{3'd0, 32'd3,        32'd4,        5'd15, 32'd12};

        @(negedge CLK);
        @(negedge CLK);
        chk("reset busy", BUSY, 1'b0);
        chk("reset valid", RESULT_VALID, 1'b0);
        chk("reset result", RESULT, 32'h0);
        chk("reset tag", TAG_OUT, 5'h0);
        RESET = 1'b0;

        for (int i = 0; i < 15; i++)
            do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp);

        // Reset in the middle of CALC clears every output at once
        @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'd5; DATA1 = 32'd1000; DATA2 = 32'd3; TAG_IN = 5'd21;
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("async reset busy", BUSY, 1'b0);
        chk("async reset valid", RESULT_VALID, 1'b0);
        chk("async reset result", RESULT, 32'h0);
        chk("async reset tag", TAG_OUT, 5'h0);
        @(negedge CLK);
        RESET = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(negedge CLK); if (RESULT_VALID || BUSY) seen = 1'b1; end
        chk("no activity after reset", seen, 1'b0);

        // Flush mid-divide with a simultaneous START: nothing survives
        @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'd4; DATA1 = 32'd12345; DATA2 = 32'd7; TAG_IN = 5'd17;
        @(negedge CLK);
        START = 1'b0;
        repeat (10) @(negedge CLK);
        FLUSH = 1'b1; START = 1'b1; FUNCT3 = 3'd0; DATA1 = 32'd9; DATA2 = 32'd9; TAG_IN = 5'd18;
        @(negedge CLK);
        FLUSH = 1'b0; START = 1'b0;
        chk("flush busy drop", BUSY, 1'b0);
        seen = 1'b0;
        repeat (40) begin @(negedge CLK); if (RESULT_VALID || BUSY) seen = 1'b1; end
        chk("flush no result", seen, 1'b0);
        do_op("mul after flush", 3'd0, 32'd3, 32'd4, 5'd19, 32'd12);

        // Flush while a fast-path result is pending
        @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'd5; DATA1 = 32'd77; DATA2 = 32'd0; TAG_IN = 5'd20;
        @(negedge CLK);
        START = 1'b0; FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        chk("flush fast pulse", RESULT_VALID, 1'b0);
        chk("flush fast result", RESULT, 32'd12);

        // START held high through BUSY with changing operands is ignored
        @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'd3; DATA1 = 32'hDEADBEEF; DATA2 = 32'h12345678; TAG_IN = 5'd22;
        @(negedge CLK);
        cyc = 0;
        while (!RESULT_VALID && cyc < 80) begin
            FUNCT3 = 3'($urandom); DATA1 = $urandom; DATA2 = $urandom; TAG_IN = 5'($urandom);
            @(negedge CLK);
            cyc++;
        end
        START = 1'b0;
        chk("held start result", RESULT, ref_model(3'd3, 32'hDEADBEEF, 32'h12345678));
        chk("held start tag", TAG_OUT, 5'd22);
        chk("held start latency", cyc, LAT);
        @(negedge CLK);
        chk("held start no restart", BUSY, 1'b0);

        // Back-to-back: START in the RESULT_VALID cycle is accepted
        @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'd0; DATA1 = 32'd11; DATA2 = 32'd13; TAG_IN = 5'd3;
        @(negedge CLK);
        START = 1'b0;
        wait_rv(cyc, busy_bad, 1'b1);
        chk("b2b first result", RESULT, 32'd143);
        START = 1'b1; FUNCT3 = 3'd5; DATA1 = 32'd1000; DATA2 = 32'd9; TAG_IN = 5'd4;
        @(negedge CLK);
        START = 1'b0;
        chk("b2b second busy", BUSY, 1'b1);
        wait_rv(cyc, busy_bad, 1'b1);
        chk("b2b second result", RESULT, 32'd111);
        chk("b2b second tag", TAG_OUT, 5'd4);
        chk("b2b second latency", cyc, LAT);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: b = b;
            endcase
            do_op($sformatf("rand%0d f3=%0d a=%0h b=%0h", i, f3, a, b), f3, a, b, 5'($urandom), ref_model(f3, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
